adsr_vca: RTL

ADSR envelope generator and VCA, placed directly downstream of the square oscillator. Consumes the oscillator's 24-bit signed val_out sample stream and a per-voice gate, and produces an amplitude-shaped sample stream. The envelope advances once per audio sample strobe. The multiply is pipelined to two clock cycles.

---
 rtl/adsr_vca.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/adsr_vca.sv
// adsr_vca: ADSR envelope generator plus a two-stage VCA multiply.
//   Sits downstream of the oscillator and shapes its signed sample stream
//   by a 16-bit unsigned envelope. The envelope and the VCA advance only on
//   sample strobes. The product for a strobe appears two clocks later.
// Ports:
//   clk_in, rst_in (async, active high)
//   sample_valid_in  : one-cycle strobe per audio sample
//   audio_in         : signed oscillator sample
//   gate_in          : key held
//   attack/decay/sustain/release controls : per-strobe steps and sustain level
//   audio_out / audio_valid_out : shaped sample and its one-cycle strobe
//   env_out, state_out, active_out : envelope register, FSM state, state != IDLE
module adsr_vca #(
  parameter int AUDIO_W = 24,
  parameter int ENV_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               sample_valid_in,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic               gate_in,
  input  logic [ENV_W-1:0]   attack_step_in,
  input  logic [ENV_W-1:0]   decay_step_in,
  input  logic [ENV_W-1:0]   sustain_level_in,
  input  logic [ENV_W-1:0]   release_step_in,
  output logic [AUDIO_W-1:0] audio_out,
  output logic               audio_valid_out,
  output logic [ENV_W-1:0]   env_out,
  output logic [2:0]         state_out,
  output logic               active_out
);

  localparam int PROD_W = AUDIO_W + ENV_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [ENV_W-1:0]           env_q, env_d;
  logic                       gate_q, gate_d;
  logic                       retrig_q, retrig_d;
  logic                       retrig_now;
  logic [2:1]                 vld_pipe_q, vld_pipe_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic [AUDIO_W-1:0]         audio_q, audio_d;

  logic [ENV_W:0]             atk_sum, dec_diff, rel_diff;
  logic [ENV_W-1:0]           env_atk, env_dec, env_rel;
  logic signed [AUDIO_W-1:0]  a_s;
  logic signed [ENV_W:0]      e_s;
  logic                       unused_prod;

  // Saturating / clamping step arithmetic, one extra bit to see carry/borrow.
  assign atk_sum  = {1'b0, env_q} + {1'b0, attack_step_in};
  assign dec_diff = {1'b0, env_q} - {1'b0, decay_step_in};
  assign rel_diff = {1'b0, env_q} - {1'b0, release_step_in};
  assign env_atk  = atk_sum[ENV_W] ? '1 : atk_sum[ENV_W-1:0];
  assign env_dec  = (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] < sustain_level_in))
                    ? sustain_level_in : dec_diff[ENV_W-1:0];
  assign env_rel  = rel_diff[ENV_W] ? '0 : rel_diff[ENV_W-1:0];

  // A rise on the strobe cycle itself counts as already latched.
  assign retrig_now = retrig_q | (gate_in & ~gate_q);

  always_comb begin
    gate_d   = gate_in;
    retrig_d = sample_valid_in ? 1'b0 : retrig_now;
    state_d  = state_q;
    env_d    = env_q;
    if (sample_valid_in) begin
      case (state_q)
        S_IDLE: begin
          env_d = '0;
          if (gate_in) begin
            state_d = S_ATTACK;
            env_d   = env_atk;
          end
        end
        S_ATTACK: begin
          if (!gate_in) begin
            state_d = S_RELEASE;
            env_d   = env_rel;
          end else begin
            env_d = env_atk;
            if (env_atk == '1) state_d = S_DECAY;
          end
        end
        S_DECAY: begin
          if (!gate_in) begin
            state_d = S_RELEASE;
            env_d   = env_rel;
          end else if (retrig_now) begin
            state_d = S_ATTACK;
            env_d   = env_atk;
          end else begin
            env_d = env_dec;
            if (env_dec == sustain_level_in) state_d = S_SUSTAIN;
          end
        end
        S_SUSTAIN: begin
          if (!gate_in) begin
            state_d = S_RELEASE;
            env_d   = env_rel;
          end else if (retrig_now) begin
            state_d = S_ATTACK;
            env_d   = env_atk;
          end else begin
            env_d = sustain_level_in;
          end
        end
        S_RELEASE: begin
          if (gate_in) begin
            state_d = S_ATTACK;
            env_d   = env_atk;
          end else begin
            env_d = env_rel;
            if (env_rel == '0) state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          env_d   = '0;
        end
      endcase
    end
  end

  // VCA: stage 1 multiplies by the pre-update envelope, stage 2 drops 16
  // fraction bits (arithmetic shift, floor). Output holds between strobes.
  assign a_s = $signed(audio_in);
  assign e_s = $signed({1'b0, env_q});

  always_comb begin
    vld_pipe_d = {vld_pipe_q[1], sample_valid_in};
    prod_d     = sample_valid_in ? (PROD_W'(a_s) * PROD_W'(e_s)) : prod_q;
    audio_d    = vld_pipe_q[1] ? prod_q[PROD_W-2:ENV_W] : audio_q;
  end

  assign unused_prod = ^{prod_q[PROD_W-1], prod_q[ENV_W-1:0]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      env_q      <= '0;
      gate_q     <= 1'b0;
      retrig_q   <= 1'b0;
      vld_pipe_q <= '0;
      prod_q     <= '0;
      audio_q    <= '0;
    end else begin
      state_q    <= state_d;
      env_q      <= env_d;
      gate_q     <= gate_d;
      retrig_q   <= retrig_d;
      vld_pipe_q <= vld_pipe_d;
      prod_q     <= prod_d;
      audio_q    <= audio_d;
    end
  end

  assign audio_out       = audio_q;
  assign audio_valid_out = vld_pipe_q[2];
  assign env_out         = env_q;
  assign state_out       = state_q;
  assign active_out      = (state_q != S_IDLE);

endmodule
